// File: rtl/ex_div_unit_pkg.sv
// Shared definitions for the EX-stage integer divider.
//   DType       : machine data word
//   DivOp       : divide/modulo opcode as presented on div_op
//   DIV_LATENCY : cycles from the accepting clock edge to the ex_finish pulse
package ex_div_unit_pkg;

  localparam int unsigned DTYPE_W = 32;

  typedef logic [DTYPE_W-1:0] DType;

  localparam int unsigned DIV_LATENCY = DTYPE_W + 1;

  typedef enum logic [1:0] {
    DIV_W  = 2'd0,
    MOD_W  = 2'd1,
    DIV_WU = 2'd2,
    MOD_WU = 2'd3
  } DivOp;

  function automatic logic op_is_signed(DivOp op);
    return (op == DIV_W) || (op == MOD_W);
  endfunction

  function automatic logic op_is_mod(DivOp op);
    return (op == MOD_W) || (op == MOD_WU);
  endfunction

endpackage

// File: rtl/ex_div_unit_div_step.sv
// One restoring-division iteration (combinational).
//   rem      : partial remainder from the previous iteration
//   rem_msb  : next dividend bit shifted into the remainder
//   divisor  : divisor magnitude
//   rem_next : partial remainder after this iteration
//   qbit     : quotient bit produced by this iteration
module ex_div_unit_div_step #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem,
  input  logic              rem_msb,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_next,
  output logic              qbit
);

  logic [DATA_W:0]   shifted;
  logic [DATA_W+1:0] trial;
  logic              unused_trial;

  // The shifted remainder can reach 2^DATA_W, so the subtraction carries an
  // extra guard bit to keep the sign test exact for large divisors.
  assign shifted      = {rem, rem_msb};
  assign trial        = {1'b0, shifted} - {2'b00, divisor};
  assign qbit         = ~trial[DATA_W+1];
  assign rem_next     = qbit ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];
  assign unused_trial = trial[DATA_W];

endmodule

// File: rtl/ex_div_unit.sv
// Multi-cycle radix-2 restoring divider for the EX stage.
//   aclk, aresetn : clock, asynchronous active-low reset
//   div_start     : request pulse, sampled in IDLE only
//   div_op        : DivOp opcode (DIV_W, MOD_W, DIV_WU, MOD_WU)
//   div_src1/2    : dividend / divisor from the forwarding network
//   flush         : abandons any operation in flight
//   div_busy      : high from the cycle after acceptance through DONE
//   ex_finish     : one-cycle completion pulse, div_result valid with it
//   div_result    : quotient or remainder, held until the next completion
module ex_div_unit
  import ex_div_unit_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = $clog2(DATA_W)
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              div_start,
  input  logic [1:0]        div_op,
  input  logic [DATA_W-1:0] div_src1,
  input  logic [DATA_W-1:0] div_src2,
  input  logic              flush,
  output logic              div_busy,
  output logic              ex_finish,
  output logic [DATA_W-1:0] div_result
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} DivState;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DATA_W - 1);

  DivState           state;
  logic              busy_q, finish_q;
  logic              mod_q, signed_q, sign1_q, sign2_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] dividend_q, divisor_q, rem_q, result_q;

  DivOp              op_in;
  logic              in_signed;
  logic [DATA_W-1:0] abs1, abs2;
  logic [DATA_W-1:0] step_rem;
  logic              step_qbit;
  logic              neg_quot, neg_rem;
  logic [DATA_W-1:0] quot_fix, rem_fix;

  assign op_in     = DivOp'(div_op);
  assign in_signed = op_is_signed(op_in);
  assign abs1      = div_src1[DATA_W-1] ? -div_src1 : div_src1;
  assign abs2      = div_src2[DATA_W-1] ? -div_src2 : div_src2;

  ex_div_unit_div_step #(
    .DATA_W (DATA_W)
  ) u_div_step (
    .rem      (rem_q),
    .rem_msb  (dividend_q[DATA_W-1]),
    .divisor  (divisor_q),
    .rem_next (step_rem),
    .qbit     (step_qbit)
  );

  // The dividend register fills with quotient bits as it shifts out.
  // A zero divisor yields an all-ones quotient; it is kept unnegated so a
  // negative dividend still returns all ones.
  assign neg_quot = signed_q & (sign1_q ^ sign2_q) & (divisor_q != '0);
  assign neg_rem  = signed_q & sign1_q;
  assign quot_fix = neg_quot ? -dividend_q : dividend_q;
  assign rem_fix  = neg_rem ? -rem_q : rem_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      busy_q     <= 1'b0;
      finish_q   <= 1'b0;
      mod_q      <= 1'b0;
      signed_q   <= 1'b0;
      sign1_q    <= 1'b0;
      sign2_q    <= 1'b0;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      result_q   <= '0;
    end else begin
      finish_q <= 1'b0;
      if (flush) begin
        state  <= IDLE;
        busy_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (div_start) begin
              mod_q      <= op_is_mod(op_in);
              signed_q   <= in_signed;
              sign1_q    <= div_src1[DATA_W-1];
              sign2_q    <= div_src2[DATA_W-1];
              dividend_q <= in_signed ? abs1 : div_src1;
              divisor_q  <= in_signed ? abs2 : div_src2;
              rem_q      <= '0;
              cnt_q      <= '0;
              busy_q     <= 1'b1;
              state      <= BUSY;
            end
          end
          BUSY: begin
            rem_q      <= step_rem;
            dividend_q <= {dividend_q[DATA_W-2:0], step_qbit};
            cnt_q      <= cnt_q + CNT_W'(1);
            if (cnt_q == CntLast) begin
              state <= DONE;
            end
          end
          DONE: begin
            result_q <= mod_q ? rem_fix : quot_fix;
            finish_q <= 1'b1;
            busy_q   <= 1'b0;
            state    <= IDLE;
          end
          default: begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        endcase
      end
    end
  end

  assign div_busy   = busy_q;
  assign ex_finish  = finish_q;
  assign div_result = result_q;

endmodule

// File: tb/tb_ex_div_unit.sv
// Scoreboard bench for ex_div_unit: stimulus pushes expected results and
// completion cycles, a negedge monitor pops and compares on each ex_finish.
module tb_ex_div_unit;
  import ex_div_unit_pkg::*;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        div_start = 1'b0;
  logic [1:0]  div_op = 2'd0;
  logic [31:0] div_src1 = '0;
  logic [31:0] div_src2 = '0;
  logic        flush = 1'b0;
  logic        div_busy;
  logic        ex_finish;
  logic [31:0] div_result;

  ex_div_unit #(
    .DATA_W (32)
  ) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .div_start  (div_start),
    .div_op     (div_op),
    .div_src1   (div_src1),
    .div_src2   (div_src2),
    .flush      (flush),
    .div_busy   (div_busy),
    .ex_finish  (ex_finish),
    .div_result (div_result)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          due;
    string       tag;
  } exp_t;

  typedef struct {
    DivOp        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    string       tag;
  } vec_t;

  exp_t        sb[$];
  exp_t        mon_e;
  vec_t        vecs[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] last_exp = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Caller is at a negedge; the request is accepted on the following posedge.
  task automatic issue(input DivOp op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input string tag, input bit push);
    div_start = 1'b1;
    div_op    = op;
    div_src1  = a;
    div_src2  = b;
    @(posedge aclk);
    #1;
    if (push) begin
      sb.push_back('{res: exp, due: cyc + int'(DIV_LATENCY), tag: tag});
      last_exp = exp;
    end
    @(negedge aclk);
    div_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < int'(DIV_LATENCY) + 8 && !seen; i++) begin
      @(negedge aclk);
      if (ex_finish) seen = 1'b1;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL %s_timeout: got no ex_finish, want a pulse", tag);
    end
  endtask

  always @(negedge aclk) begin
    if (aresetn && ex_finish) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pulse: got ex_finish=1 at cycle %0d, want none", cyc);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.tag, "_result"}, div_result, mon_e.res);
        check({mon_e.tag, "_latency"}, 32'(cyc), 32'(mon_e.due));
      end
    end
  end

  initial begin
    vecs.push_back('{DIV_W,  32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, "divw_7_m2"});
    vecs.push_back('{MOD_W,  32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, "modw_7_m2"});
    vecs.push_back('{MOD_W,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, "modw_m7_2"});
    vecs.push_back('{DIV_W,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, "divw_m7_2"});
    vecs.push_back('{DIV_WU, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, "divwu_ff_10"});
    vecs.push_back('{MOD_WU, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, "modwu_ff_10"});
    vecs.push_back('{DIV_W,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "divw_ovf"});
    vecs.push_back('{MOD_W,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "modw_ovf"});
    vecs.push_back('{DIV_WU, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF, "divwu_by0"});
    vecs.push_back('{MOD_W,  32'h0000_1234, 32'h0000_0000, 32'h0000_1234, "modw_by0"});
    vecs.push_back('{DIV_W,  32'hFFFF_FF9C, 32'h0000_0000, 32'hFFFF_FFFF, "divw_neg_by0"});
    vecs.push_back('{MOD_W,  32'hFFFF_FF9C, 32'h0000_0000, 32'hFFFF_FF9C, "modw_neg_by0"});
    vecs.push_back('{DIV_WU, 32'hFFFF_FFFF, 32'h8000_0001, 32'h0000_0001, "divwu_bigdiv"});
    vecs.push_back('{MOD_WU, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, "modwu_bigdiv"});
    vecs.push_back('{DIV_W,  32'h0000_0064, 32'h0000_0007, 32'h0000_000E, "divw_100_7"});
    vecs.push_back('{MOD_W,  32'hFFFF_FF9C, 32'h0000_0007, 32'hFFFF_FFFE, "modw_m100_7"});

    repeat (2) @(negedge aclk);
    check("reset_busy", 32'(div_busy), 32'd0);
    check("reset_finish", 32'(ex_finish), 32'd0);
    check("reset_result", div_result, 32'd0);
    aresetn = 1'b1;
    @(negedge aclk);

    // Each issue follows the completing negedge directly, so every pair is
    // a back-to-back start in the post-DONE IDLE cycle.
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].tag, 1'b1);
      wait_done(vecs[i].tag);
    end

    // Request held high through BUSY must not be accepted twice.
    issue(DIV_WU, 32'h0000_0064, 32'h0000_000A, 32'h0000_000A, "hold", 1'b1);
    div_start = 1'b1;
    div_src1  = 32'h0000_0005;
    repeat (29) @(negedge aclk);
    check("hold_busy", 32'(div_busy), 32'd1);
    div_start = 1'b0;
    wait_done("hold");
    check("hold_idle", 32'(div_busy), 32'd0);

    // Flush together with a new start at cycle 10 of a divide.
    @(negedge aclk);
    issue(DIV_W, 32'h0000_0009, 32'h0000_0003, 32'h0000_0003, "flushed", 1'b0);
    repeat (8) @(negedge aclk);
    flush     = 1'b1;
    div_start = 1'b1;
    div_src1  = 32'h0000_0077;
    @(posedge aclk);
    #1;
    check("flush_busy", 32'(div_busy), 32'd0);
    check("flush_finish", 32'(ex_finish), 32'd0);
    check("flush_result", div_result, last_exp);
    @(negedge aclk);
    flush     = 1'b0;
    div_start = 1'b0;
    repeat (40) @(negedge aclk);
    check("flush_result_held", div_result, last_exp);
    issue(MOD_WU, 32'h0000_0009, 32'h0000_0004, 32'h0000_0001, "after_flush", 1'b1);
    wait_done("after_flush");

    // Reset asserted at cycle 20 of a divide.
    @(negedge aclk);
    issue(DIV_W, 32'h0000_0030, 32'h0000_0004, 32'h0000_000C, "reset_mid", 1'b0);
    repeat (18) @(negedge aclk);
    aresetn = 1'b0;
    #1;
    check("rst_mid_busy", 32'(div_busy), 32'd0);
    check("rst_mid_finish", 32'(ex_finish), 32'd0);
    check("rst_mid_result", div_result, 32'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    repeat (40) @(negedge aclk);
    issue(DIV_W, 32'h0000_0030, 32'hFFFF_FFFC, 32'hFFFF_FFF4, "after_reset", 1'b1);
    wait_done("after_reset");

    repeat (3) @(negedge aclk);
    check("scoreboard_drain", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
